// File: rtl/cpu_pkg.sv
// Shared MIPS core types and constants used by the register file and its scoreboard.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_COUNT      = 2 ** REG_ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0]     word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at writeback.
// Same-cycle write forwarding of hazards is enabled by REGFILE_WRITE_BYPASS_EN.
module register_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int unsigned REG_COUNT  = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic                  pending_set_i,
    input  logic [ADDR_WIDTH-1:0] pending_addr_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_0_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_1_i,
    output logic                  hazard_0_o,
    output logic                  hazard_1_o,
    output logic [REG_COUNT-1:0]  pending_mask_o
);

    logic [REG_COUNT-1:0] mask_d, mask_q;

    // Clear first so a same-cycle set on the same register (newer producer) wins.
    always_comb begin
        mask_d = mask_q;
        if (write_enable_i) begin
            mask_d[write_addr_i] = 1'b0;
        end
        if (pending_set_i) begin
            mask_d[pending_addr_i] = 1'b1;
        end
        mask_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    always_comb begin
        hazard_0_o = mask_q[read_addr_0_i];
        hazard_1_o = mask_q[read_addr_1_i];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_enable_i && (write_addr_i != '0) && (write_addr_i == read_addr_0_i) &&
            !(pending_set_i && (pending_addr_i == read_addr_0_i))) begin
            hazard_0_o = 1'b0;
        end
        if (write_enable_i && (write_addr_i != '0) && (write_addr_i == read_addr_1_i) &&
            !(pending_set_i && (pending_addr_i == read_addr_1_i))) begin
            hazard_1_o = 1'b0;
        end
`endif
    end

    assign pending_mask_o = mask_q;

endmodule

// File: rtl/register_file_32.sv
// MIPS general-purpose register file: two combinational reads, one synchronous write,
// r0 hardwired to zero, integrated pending-write scoreboard. Optional REGFILE_WRITE_BYPASS_EN.
module register_file_32
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int unsigned REG_COUNT  = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_addr_0,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  pending_set,
    input  logic [ADDR_WIDTH-1:0] pending_addr,
    output logic                  hazard_0,
    output logic                  hazard_1,
    output logic [REG_COUNT-1:0]  pending_mask
);

    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic                  write_live;

    assign write_live = write_enable && (write_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (write_live) begin
            regs_d[write_addr] = write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        read_data_0 = (read_addr_0 == '0) ? '0 : regs_q[read_addr_0];
        read_data_1 = (read_addr_1 == '0) ? '0 : regs_q[read_addr_1];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_live && (write_addr == read_addr_0)) begin
            read_data_0 = write_data;
        end
        if (write_live && (write_addr == read_addr_1)) begin
            read_data_1 = write_data;
        end
`endif
    end

    register_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .write_enable_i (write_enable),
        .write_addr_i   (write_addr),
        .pending_set_i  (pending_set),
        .pending_addr_i (pending_addr),
        .read_addr_0_i  (read_addr_0),
        .read_addr_1_i  (read_addr_1),
        .hazard_0_o     (hazard_0),
        .hazard_1_o     (hazard_1),
        .pending_mask_o (pending_mask)
    );

endmodule
